// File: rtl/tetris_move_scheduler_if.sv
// Command handshake between the move scheduler and the datapath move port.
// master: drives cmd_valid/cmd, samples cmd_ready. slave: the reverse.
interface tetris_move_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;

    modport master (
        output cmd_valid,
        output cmd,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        output cmd_ready
    );
endinterface

// File: rtl/tetris_move_scheduler.sv
// Merges gravity, key edges, auto-repeat and hard drop into one command stream.
// Ports: i_clk, i_rst (async high), i_key_* levels, i_level, i_gamestate,
//        i_touchdown, o_cmd (valid/ready/cmd bus), o_sched_state.
module tetris_move_scheduler #(
    parameter int         GRAV_BASE = 25_000_000,
    parameter int         GRAV_STEP = 2_000_000,
    parameter int         GRAV_MIN  = 2_500_000,
    parameter int         DAS_DELAY = 8_000_000,
    parameter int         DAS_RATE  = 2_500_000,
    parameter logic [1:0] RUN_CODE  = 2'd1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_key_left,
    input  logic                           i_key_right,
    input  logic                           i_key_down,
    input  logic                           i_key_rot,
    input  logic                           i_key_drop,
    input  logic [3:0]                     i_level,
    input  logic [1:0]                     i_gamestate,
    input  logic                           i_touchdown,
    tetris_move_scheduler_if.master        o_cmd,
    output logic [1:0]                     o_sched_state
);

    localparam int GW   = 26;
    localparam int DMAX = (DAS_DELAY > DAS_RATE) ? DAS_DELAY : DAS_RATE;
    localparam int DW   = $clog2(DMAX + 1);

    localparam logic [DW-1:0] L_DELAY = DW'(DAS_DELAY);
    localparam logic [DW-1:0] L_RATE  = DW'(DAS_RATE);

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_LEFT  = 3'd1;
    localparam logic [2:0] C_RIGHT = 3'd2;
    localparam logic [2:0] C_DOWN  = 3'd3;
    localparam logic [2:0] C_ROT   = 3'd4;
    localparam logic [2:0] C_DROP  = 3'd5;

    // Pending bit positions
    localparam int P_GRAV  = 0;
    localparam int P_DOWN  = 1;
    localparam int P_RIGHT = 2;
    localparam int P_LEFT  = 3;
    localparam int P_ROT   = 4;
    localparam int P_DROP  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_valid;
    logic [2:0]     r_cmd;
    logic [5:0]     r_pend;
    logic [GW-1:0]  r_grav;
    logic [4:0]     r_hist;
    // Auto-repeat counters: 0 down, 1 right, 2 left (same order as w_keys)
    logic [DW-1:0]  r_das_cnt [3];
    logic [2:0]     r_das_ph;

    logic [4:0]     w_keys;
    logic [4:0]     w_edge;
    logic           w_gs_run;
    logic           w_run;
    logic           w_ev_en;
    logic           w_conflict;
    logic [2:0]     w_fire;
    logic [GW-1:0]  w_step;
    logic [GW-1:0]  w_base;
    logic [GW-1:0]  w_min;
    logic [GW-1:0]  w_period;
    logic           w_grav_fire;
    logic [5:0]     w_ev;
    logic [5:0]     w_req;
    logic [5:0]     w_clr;
    logic [2:0]     w_sel;
    logic           w_xfer;
    logic           w_load;

    assign w_keys     = {i_key_drop, i_key_rot, i_key_left,
                         i_key_right, i_key_down};
    assign w_edge     = w_keys & ~r_hist;
    assign w_gs_run   = (i_gamestate == RUN_CODE);
    assign w_run      = (r_state == S_RUN) && w_gs_run;
    assign w_ev_en    = w_run && !i_touchdown;
    assign w_conflict = i_key_left && i_key_right;

    // Subtraction guarded so high levels clamp to the floor instead of wrapping
    assign w_step   = GW'(i_level) * GW'(GRAV_STEP);
    assign w_base   = GW'(GRAV_BASE);
    assign w_min    = GW'(GRAV_MIN);
    assign w_period = (w_step >= w_base || (w_base - w_step) < w_min)
                      ? w_min : (w_base - w_step);

    assign w_grav_fire = w_ev_en && (r_grav >= w_period - GW'(1));

    always_comb begin
        w_fire = '0;
        for (int i = 0; i < 3; i++) begin
            w_fire[i] = w_keys[i] && r_hist[i] &&
                        (r_das_cnt[i] == (r_das_ph[i] ? L_RATE : L_DELAY)) &&
                        !(i != 0 && w_conflict);
        end
    end

    always_comb begin
        w_ev          = '0;
        w_ev[P_DROP]  = w_edge[4];
        w_ev[P_ROT]   = w_edge[3];
        w_ev[P_LEFT]  = w_edge[2] | w_fire[2];
        w_ev[P_RIGHT] = w_edge[1] | w_fire[1];
        w_ev[P_DOWN]  = w_edge[0] | w_fire[0];
        w_ev[P_GRAV]  = w_grav_fire;
        if (!w_ev_en) begin
            w_ev = '0;
        end
    end

    assign w_req = r_pend | w_ev;

    always_comb begin
        w_sel = C_NONE;
        w_clr = '0;
        if (w_req[P_DROP]) begin
            w_sel = C_DROP;
            w_clr[P_DROP] = 1'b1;
        end else if (w_req[P_ROT]) begin
            w_sel = C_ROT;
            w_clr[P_ROT] = 1'b1;
        end else if (w_req[P_LEFT]) begin
            w_sel = C_LEFT;
            w_clr[P_LEFT] = 1'b1;
        end else if (w_req[P_RIGHT]) begin
            w_sel = C_RIGHT;
            w_clr[P_RIGHT] = 1'b1;
        end else if (w_req[P_DOWN] || w_req[P_GRAV]) begin
            // Key down and gravity collapse into one DOWN
            w_sel = C_DOWN;
            w_clr[P_DOWN] = 1'b1;
            w_clr[P_GRAV] = 1'b1;
        end
    end

    assign w_xfer = r_valid && o_cmd.cmd_ready;
    // Touchdown suppresses loading so pendings it clears never issue
    assign w_load = w_ev_en && (!r_valid || o_cmd.cmd_ready) &&
                    (w_sel != C_NONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_cmd    <= C_NONE;
            r_pend   <= '0;
            r_grav   <= '0;
            r_hist   <= '0;
            r_das_ph <= '0;
            for (int i = 0; i < 3; i++) begin
                r_das_cnt[i] <= '0;
            end
        end else begin
            r_hist <= w_keys;

            if (!w_gs_run) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_RUN;
                    S_RUN: begin
                        if (w_xfer && r_cmd == C_DROP) begin
                            r_state <= S_LOCK;
                        end
                    end
                    S_LOCK: begin
                        if (i_touchdown) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            // Offered command is held until accepted, never preempted
            if (w_load) begin
                r_valid <= 1'b1;
                r_cmd   <= w_sel;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
                r_cmd   <= C_NONE;
            end

            if (r_state == S_IDLE || !w_gs_run || i_touchdown) begin
                r_pend <= '0;
            end else if (w_run) begin
                r_pend <= w_req & ~(w_load ? w_clr : 6'd0);
            end

            if (!w_ev_en) begin
                r_grav <= '0;
            end else if (w_grav_fire || (w_load && w_sel == C_DOWN)) begin
                r_grav <= '0;
            end else begin
                r_grav <= r_grav + GW'(1);
            end

            // A zero counter means "not started": only a press edge or a
            // touchdown reload arms auto-repeat.
            for (int i = 0; i < 3; i++) begin
                if (r_state == S_IDLE || !w_gs_run || !w_keys[i]) begin
                    r_das_cnt[i] <= '0;
                    r_das_ph[i]  <= 1'b0;
                end else if (i_touchdown || w_edge[i]) begin
                    r_das_cnt[i] <= DW'(1);
                    r_das_ph[i]  <= 1'b0;
                end else if (i != 0 && w_conflict) begin
                    r_das_cnt[i] <= '0;
                    r_das_ph[i]  <= 1'b0;
                end else if (w_fire[i]) begin
                    r_das_cnt[i] <= DW'(1);
                    r_das_ph[i]  <= 1'b1;
                end else if (r_das_cnt[i] != '0) begin
                    r_das_cnt[i] <= r_das_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign o_cmd.cmd_valid = r_valid;
    assign o_cmd.cmd       = r_cmd;
    assign o_sched_state   = r_state;

endmodule

// File: doc/tetris_move_scheduler.md
# tetris_move_scheduler

Arbitrates every piece-motion request for the Tetris datapath (gravity, left, right, soft drop, rotate, hard drop) into one command stream with a valid/ready handshake. It sits between the key decode and game-state logic and the datapath's move port. It owns the level-scaled gravity timer, key auto-repeat, and the lock-wait after a hard drop, so the datapath never sees two moves in one cycle.

## Interface
- GRAV_BASE, 25_000_000: gravity period in cycles at level 0
- GRAV_STEP, 2_000_000: period reduction per level
- GRAV_MIN, 2_500_000: floor on gravity period
- DAS_DELAY, 8_000_000: hold cycles before auto-repeat starts (left/right/down)
- DAS_RATE, 2_500_000: cycles between auto-repeats
- RUN_CODE, 2'd1: gamestate value meaning "running"
- Clk  in  1  system clock (50 MHz); sole clock
- Reset  in  1  asynchronous, active-high reset
- key_left, key_right, key_down, key_rot, key_drop  in  1 each  synchronous level key states
- level  in  4  current level, 0..15
- gamestate  in  2  game state; moves are scheduled only when equal to RUN_CODE
- touchdown  in  1  one-cycle pulse: piece locked, new piece spawned
- cmd_ready  in  1  datapath accepts cmd this cycle
- cmd_valid  out  1  command offered
- cmd  out  3  0 none, 1 LEFT, 2 RIGHT, 3 DOWN, 4 ROT, 5 HARDDROP
- sched_state  out  2  0 IDLE, 1 RUN, 2 LOCKWAIT

## Operation
- States:
  - IDLE: gamestate != RUN_CODE. Pendings cleared, gravity counter held at 0, DAS counters cleared.
  - IDLE -> RUN when gamestate == RUN_CODE.
  - RUN -> LOCKWAIT on transfer of HARDDROP.
  - LOCKWAIT -> RUN on touchdown.
  - RUN/LOCKWAIT -> IDLE when gamestate leaves RUN_CODE.
- Events set sticky pending bits p_drop, p_rot, p_left, p_right, p_down, p_grav:
  - Rising edges of key_drop, key_rot, key_left, key_right and key_down set their pending bit.
  - Each auto-repeat fire sets the matching bit.
  - Gravity expiry sets p_grav.
  - A pending bit that is already set does not accumulate.
- Auto-repeat (left/right/down, each independent):
  - The DAS counter starts on the press edge.
  - At DAS_DELAY cycles held, the key fires and the counter reloads.
  - Afterwards it fires every DAS_RATE cycles while the key is held.
  - Release clears the counter.
  - If key_left and key_right are both held, neither auto-repeats; edges still register.
- Gravity:
  - period = max(GRAV_BASE − level×GRAV_STEP, GRAV_MIN), computed at 26 bits, no underflow wrap.
  - The counter increments each RUN cycle. When counter ≥ period−1, it sets p_grav and resets to 0.
  - A level change takes effect on the next compare.
  - The counter is held at 0 in IDLE and LOCKWAIT.
- Arbitration, fixed priority: HARDDROP > ROT > LEFT > RIGHT > DOWN.
  - DOWN is issued if p_down or p_grav is set.
  - Loading DOWN clears both p_down and p_grav, and restarts the gravity counter.
  - Loading a command clears its pending bit.
- touchdown (RUN or LOCKWAIT):
  - Clears all pending bits.
  - Zeroes the gravity counter.
  - Reloads held DAS counters to the start of the DAS_DELAY phase.
- LOCKWAIT: key edges and repeats are ignored; nothing is loaded.
- Leaving RUN_CODE while a command is offered: cmd_valid holds until accepted, then nothing more is loaded.

## Timing
- Reset values: cmd_valid=0, cmd=0, sched_state=0, all pendings/counters 0, key history 0.
- Arbitration sees pending | this-cycle events. A key low at edge N−1 and high at edge N gives cmd_valid=1 after edge N (1-cycle latency).
- Transfer occurs at a rising edge with cmd_valid && cmd_ready.
- The next command may load on the same edge (back-to-back, 1 per cycle).
- While cmd_valid && !cmd_ready, cmd is stable. New events only set pendings and never preempt the offered command.
- cmd is 0 whenever cmd_valid=0.
- A touchdown on the same edge as a transfer: the transfer completes; pendings are cleared after it.
- A touchdown and a key edge on the same cycle: touchdown wins; the edge is dropped.
- Gravity expiry on the same edge a DOWN loads: merged, single DOWN.
- Async Reset mid-stall drops cmd_valid immediately.

## Test plan
Bench parameters: GRAV_BASE=20, GRAV_STEP=4, GRAV_MIN=6, DAS_DELAY=8, DAS_RATE=3.

- **Gravity, level 0:** level=0, RUN, cmd_ready=1, no keys -> DOWN transfer every 20 cycles. level=5 -> every 6 cycles (floor), never fewer.
- **Priority under stall:** cmd_ready=0; pulse key_left, then key_rot, then key_drop on separate cycles -> LEFT offered and stable. With cmd_ready=1 -> LEFT, HARDDROP, ROT on consecutive cycles. Then sched_state=2 and no gravity until touchdown.
- **Auto-repeat:** hold key_right 20 cycles, cmd_ready=1 -> RIGHT at cycles 1, 9, 12, 15, 18. Hold both left and right -> one LEFT, one RIGHT, no repeats.
- **Down/gravity merge:** press key_down on the cycle gravity expires -> exactly one DOWN; the next gravity DOWN comes 20 cycles later.
- **Touchdown clears pendings:** stall with p_rot and p_left pending, pulse touchdown -> only the offered command transfers, no further commands until new events.
- **Reset and pause:** assert Reset mid-stall -> cmd_valid=0 immediately, sched_state=0. gamestate≠RUN_CODE -> no commands, gravity counter held at 0.
